// File: rtl/fir_tap_serial.sv
// fir_tap_serial: N-tap direct-form FIR built around one time-multiplexed MAC.
//
// Every accepted sample shifts the delay line. The block then runs N_TAPS
// multiply-accumulate cycles. The full-precision sum is rounded (half toward
// +inf), saturated to NB_DATA bits, and registered into o_data. A one-cycle
// o_valid strobe follows. Coefficients can be written only while idle, so they
// stay stable for a whole computation.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid, i_data         sample input; accepted when i_valid && o_ready
//   o_ready, o_busy         ready only in IDLE; o_busy = ~o_ready
//   i_coef_we/addr/coef     coefficient write port (honoured only in IDLE)
//   o_valid, o_data         result strobe and held result
`timescale 1ns/1ps
module fir_tap_serial #(
    parameter int N_TAPS   = 8,
    parameter int NB_DATA  = 8,
    parameter int NB_COEF  = 8,
    parameter int NBF_COEF = 6,
    localparam int NB_ADDR = $clog2(N_TAPS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic               o_busy,
    input  logic               i_coef_we,
    input  logic [NB_ADDR-1:0] i_coef_addr,
    input  logic [NB_COEF-1:0] i_coef,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data
);

    localparam int NB_PROD = NB_DATA + NB_COEF;
    localparam int NB_ACC  = NB_PROD + $clog2(N_TAPS);
    // One guard bit so that adding the rounding constant cannot overflow.
    localparam int NB_RND  = NB_ACC + 1;

    localparam logic signed [NB_RND-1:0] RND_HALF = NB_RND'(1) << (NBF_COEF - 1);
    localparam logic signed [NB_RND-1:0] SAT_MAX  = NB_RND'((1 << (NB_DATA - 1)) - 1);
    localparam logic signed [NB_RND-1:0] SAT_MIN  = NB_RND'(-(1 << (NB_DATA - 1)));
    localparam logic [NB_ADDR-1:0]       IDX_LAST = NB_ADDR'(N_TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [NB_DATA-1:0]  x_q [N_TAPS];
    logic signed [NB_COEF-1:0]  h_q [N_TAPS];
    logic signed [NB_ACC-1:0]   acc_q, acc_d;
    logic [NB_ADDR-1:0]         idx_q, idx_d;
    logic [NB_DATA-1:0]         data_q, data_d;

    logic                       accept;
    logic                       coef_wr;
    logic signed [NB_PROD-1:0]  prod;
    logic signed [NB_ACC-1:0]   sum;
    logic signed [NB_RND-1:0]   sum_ext;
    logic signed [NB_RND-1:0]   sum_rnd;
    logic signed [NB_RND-1:0]   shifted;
    logic [NB_DATA-1:0]         sat;

    assign accept  = i_valid && (state_q == IDLE);
    assign coef_wr = i_coef_we && (state_q == IDLE) && (32'(i_coef_addr) < N_TAPS);

    // ---------------- MAC datapath ----------------
    assign prod    = x_q[idx_q] * h_q[idx_q];
    assign sum     = acc_q + {{(NB_ACC - NB_PROD){prod[NB_PROD-1]}}, prod};
    assign sum_ext = {sum[NB_ACC-1], sum};
    assign sum_rnd = sum_ext + RND_HALF;
    assign shifted = sum_rnd >>> NBF_COEF;

    always_comb begin
        if (shifted > SAT_MAX)      sat = SAT_MAX[NB_DATA-1:0];
        else if (shifted < SAT_MIN) sat = SAT_MIN[NB_DATA-1:0];
        else                        sat = shifted[NB_DATA-1:0];
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
                // The final sum bypasses acc_q and goes straight to the output
                // register, so DONE follows the last MAC cycle directly.
                if (idx_q == IDX_LAST) begin
                    data_d  = sat;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Delay line: shifts only on an accepted sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_TAPS; k++) x_q[k] <= '0;
        end else if (accept) begin
            x_q[0] <= i_data;
            for (int k = 1; k < N_TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient bank. A write in the same IDLE cycle as an accept is used by
    // that computation, because MAC reads h_q only from the next cycle on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_TAPS; k++) h_q[k] <= '0;
        end else if (coef_wr) begin
            h_q[i_coef_addr] <= i_coef;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = ~o_ready;
    assign o_valid = (state_q == DONE);
    assign o_data  = data_q;

endmodule

// File: tb/tb_fir_tap_serial.sv
`timescale 1ns/1ps
module tb_fir_tap_serial;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = '0;
    logic       o_ready, o_busy, o_valid;
    logic       i_coef_we = 1'b0;
    logic [2:0] i_coef_addr = '0;
    logic [7:0] i_coef = '0;
    logic [7:0] o_data;

    fir_tap_serial dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .i_coef_we  (i_coef_we),
        .i_coef_addr(i_coef_addr),
        .i_coef     (i_coef),
        .o_valid    (o_valid),
        .o_data     (o_data)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [7:0] d;
        int                c;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic signed [7:0] held;
        logic              prev_v;
        exp_t              e;
        held   = '0;
        prev_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                held   = '0;
                prev_v = 1'b0;
            end else begin
                if (o_valid) begin
                    check("valid_single_cycle", int'(prev_v), 0);
                    if (sbq.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("out_data", int'($signed(o_data)), int'(e.d));
                        check("latency", cyc - e.c, 9);
                    end
                    held = o_data;
                end else begin
                    check("data_hold", int'($signed(o_data)), int'(held));
                end
                prev_v = o_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic signed [7:0] d, input logic signed [7:0] e,
                        input bit wr = 1'b0, input logic [7:0] wc = 8'h00);
        int t = 0;
        @(negedge i_clk);
        while (!o_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        i_valid = 1'b1;
        i_data  = d;
        if (wr) begin
            i_coef_we   = 1'b1;
            i_coef_addr = 3'd0;
            i_coef      = wc;
        end
        sbq.push_back('{e, cyc});
        @(negedge i_clk);
        i_valid   = 1'b0;
        i_coef_we = 1'b0;
        i_data    = 8'h5A;   // changes outside accept must be ignored
    endtask

    task automatic load_coef(input logic [2:0] a, input logic [7:0] v);
        @(negedge i_clk);
        i_coef_we   = 1'b1;
        i_coef_addr = a;
        i_coef      = v;
        @(negedge i_clk);
        i_coef_we   = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_ready", int'(o_ready), 1);
        check("rst_busy",  int'(o_busy),  0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_data",  int'(o_data),  0);
        i_rst = 1'b0;

        // Impulse: h[k]=k+1, feed 64 then zeros -> 1..8
        for (int k = 0; k < 8; k++) load_coef(3'(k), 8'(k + 1));
        send(8'sd64, 8'sd1);
        for (int k = 1; k < 8; k++) send(8'sd0, 8'(k + 1));
        drain();

        // Rounding with h[0]=0.5
        do_reset();
        load_coef(3'd0, 8'd32);
        send(8'sd3, 8'sd2);
        send(-8'sd3, -8'sd1);
        send(8'sd1, 8'sd1);
        send(-8'sd1, 8'sd0);
        drain();

        // Saturation, positive then negative
        do_reset();
        for (int k = 0; k < 8; k++) load_coef(3'(k), 8'd64);
        for (int k = 0; k < 8; k++) send(8'sd127, 8'sd127);
        drain();
        do_reset();
        for (int k = 0; k < 8; k++) load_coef(3'(k), 8'd64);
        for (int k = 0; k < 8; k++) send(-8'sd128, -8'sd128);
        drain();

        // Handshake: i_valid held high, data changes every cycle
        do_reset();
        load_coef(3'd0, 8'd64);
        for (int j = 0; j < 40; j++) begin
            logic signed [7:0] v;
            v = 8'(j * 3 - 40);
            i_valid = 1'b1;
            i_data  = v;
            if (j % 10 == 0) sbq.push_back('{v, cyc});
            check("busy_is_not_ready", int'(o_busy), int'(!o_ready));
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        drain();

        // Coefficient-write gating
        do_reset();
        load_coef(3'd0, 8'd64);
        load_coef(3'd1, 8'd64);
        send(8'sd10, 8'sd10);
        @(negedge i_clk);
        i_coef_we   = 1'b1;      // lands during MAC: must be ignored
        i_coef_addr = 3'd0;
        i_coef      = 8'd0;
        @(negedge i_clk);
        i_coef_we   = 1'b0;
        send(8'sd10, 8'sd20);
        send(8'sd10, 8'sd10, 1'b1, 8'd0);  // IDLE write + accept together
        drain();

        // Reset mid-operation
        do_reset();
        load_coef(3'd0, 8'd64);
        send(8'sd50, 8'sd50);
        drain();
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 8'sd20;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_data",  int'(o_data),  0);
        check("midrst_ready", int'(o_ready), 1);
        check("midrst_valid", int'(o_valid), 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (15) @(negedge i_clk);   // monitor flags any stray o_valid
        send(8'sd33, 8'sd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_serial.md
Name: fir_tap_serial

Overview:
- Parametrised N-tap direct-form FIR filter built around a single time-multiplexed multiply-accumulate unit.
- Each accepted sample is followed by N_TAPS MAC cycles; the result is then rounded, saturated and presented with a one-cycle valid strobe.
- Coefficients are runtime-loadable through a write port. The block replaces fixed-coefficient, fixed-3-tap filters in the DSP datapath.

Parameters:
- N_TAPS, 8, number of taps (>=2).
- NB_DATA, 8, input/output sample width, signed two's complement.
- NB_COEF, 8, coefficient width, signed two's complement.
- NBF_COEF, 6, coefficient fractional bits (>=1); output keeps the input's fractional format.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input sample valid.
- i_data  in  NB_DATA  input sample.
- o_ready  out  1  block can accept a sample this cycle.
- o_busy  out  1  equals ~o_ready.
- i_coef_we  in  1  coefficient write enable.
- i_coef_addr  in  clog2(N_TAPS)  tap index to write.
- i_coef  in  NB_COEF  coefficient value.
- o_valid  out  1  one-cycle pulse: o_data updated.
- o_data  out  NB_DATA  filtered sample, held until the next result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; delay line x[0..N_TAPS-1]=0; all coefficients h[k]=0; accumulator=0; o_data=0; o_valid=0; o_ready=1.
- Sample accept: i_valid && o_ready on a rising edge. Same edge: x[0]<=i_data, x[k]<=x[k-1], acc<=0, idx<=0, state->MAC. i_valid while not ready is ignored; no buffering.
- MAC state (exactly N_TAPS cycles):
  - acc <= acc + x[idx]*h[idx]; idx++.
  - Product width is NB_DATA+NB_COEF. Accumulator width is NB_DATA+NB_COEF+clog2(N_TAPS), full precision, never wraps.
  - On the cycle where idx==N_TAPS-1, the final sum (acc+last product) is rounded and saturated and registered into o_data. State->DONE.
- Rounding: add 2^(NBF_COEF-1), then arithmetic shift right by NBF_COEF (round half toward +inf).
- Saturation: clamp to [-2^(NB_DATA-1), 2^(NB_DATA-1)-1].
- DONE state (1 cycle): o_valid=1, o_ready=0. State->IDLE.
- Latency: accept edge at cycle 0; o_valid high in cycle N_TAPS+1. Throughput is one sample per N_TAPS+2 cycles.
- o_ready=1 only in IDLE. o_valid=0 in every state except DONE.
- Coefficient write:
  - When i_coef_we && state==IDLE, h[i_coef_addr]<=i_coef at the edge.
  - Writes in MAC/DONE are ignored, so coefficients stay stable for a whole computation.
  - An addr >= N_TAPS is ignored.
  - A write and a sample accept in the same IDLE cycle are both performed. The new coefficient is used by this computation because MAC starts next cycle.
- Reset mid-MAC or mid-DONE: computation is abandoned, no o_valid, all registers go to reset values (coefficients included).
- i_data is sampled only on accept; changes at other times have no effect.

Test Plan:
- Impulse: load h[k]=k+1 (raw), k=0..7. Feed 64, then seven 0s, each sent on o_ready. Required outputs: 1,2,3,4,5,6,7,8. Each o_valid arrives exactly 9 cycles after its accept edge.
- Rounding: h[0]=32 (0.5), others 0. Input 3 -> 2; input -3 -> -1; input 1 -> 1; input -1 -> 0.
- Saturation: all h=64 (1.0). Feed 127 eight times -> 127,127,...; after reset, feed -128 eight times -> -128,-128,...; no wrap-around.
- Handshake/busy: hold i_valid=1 continuously with varying i_data. Only the values present in IDLE cycles are consumed (one every 10 cycles). o_busy=~o_ready throughout; o_valid is a single-cycle pulse and o_data holds between pulses.
- Coefficient-write gating: with h[0]=64, accept sample 10. Write h[0]=0 during MAC -> output 10, and a following sample 10 still gives 20 (write ignored). Write h[0]=0 in IDLE together with accepting sample 10 -> output 10 (x[1]=10, h[1]=64 if loaded, otherwise 0).
- Reset mid-operation: assert i_rst asynchronously 3 cycles after accept -> o_valid never pulses; o_data=0, o_ready=1 immediately; a subsequent accept with all-zero coefficients -> output 0.
